// File: rtl/cpu_pkg.sv
// ============================================================================
// Package     : cpu_pkg
// Description : Shared definitions for the CPU control sequencer. It holds
//               the sequencer state encoding, the opcode nibble values, the
//               stack sub-op field values and the two full-word opcodes
//               (return and stop).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  // Sequencer states. The encoding is visible on the state output port.
  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC1 = 3'd1,
    ST_EXEC2 = 3'd2,
    ST_MULW  = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  // Opcode nibble, taken from instruction[INSTR_W-1 -: 4]
  localparam logic [3:0] OP_ALU   = 4'b0100;
  localparam logic [3:0] OP_STACK = 4'b0110;  // PUSH/POP, told apart by [11:10]
  localparam logic [3:0] OP_LDI   = 4'b0111;
  localparam logic [2:0] OP_MUL   = 3'b100;   // upper three bits only; bit 0 is free
  localparam logic [3:0] OP_JMD   = 4'b1100;
  localparam logic [3:0] OP_CALL  = 4'b1101;

  // Stack sub-op field, instruction[11:10]
  localparam logic [1:0] SUB_PUSH = 2'b00;
  localparam logic [1:0] SUB_POP  = 2'b10;

  // Instructions recognised by their complete word
  localparam logic [15:0] RTN_WORD = 16'hF000;
  localparam logic [15:0] STP_WORD = 16'hF010;

endpackage

`default_nettype wire

// File: rtl/stack_pointer.sv
// ============================================================================
// Module      : stack_pointer
// Description : Bounded stack pointer. It counts up on i_inc and down on
//               i_dec, and never goes past STACK_DEPTH or below zero.
//               It also reports full and empty.
// Ports       : i_clk      - system clock, rising edge
//               i_reset_n  - asynchronous active-low reset (sp -> 0)
//               i_inc      - push request
//               i_dec      - pop request
//               o_sp       - registered stack pointer
//               o_full     - sp == STACK_DEPTH
//               o_empty    - sp == 0
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stack_pointer #(
  parameter  int STACK_DEPTH = 8,
  localparam int SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_inc,
  input  logic            i_dec,
  output logic [SP_W-1:0] o_sp,
  output logic            o_full,
  output logic            o_empty
);

  logic [SP_W-1:0] r_sp;

  assign o_sp    = r_sp;
  assign o_full  = (r_sp == SP_W'(STACK_DEPTH));
  assign o_empty = (r_sp == '0);

  // The bounds are also enforced here. A bad request from the caller then
  // cannot wrap the pointer.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sp <= '0;
    end else if (i_inc && !i_dec && !o_full) begin
      r_sp <= r_sp + 1'b1;
    end else if (i_dec && !i_inc && !o_empty) begin
      r_sp <= r_sp - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_sequencer.sv
// ============================================================================
// Module      : instr_sequencer
// Description : Fetch/execute control sequencer. It waits on the memory-ready
//               handshake, takes multiple cycles for LDI and MUL, traps stack
//               overflow and underflow into HALT, and leaves HALT on a
//               resume pulse.
// Configuration macro:
//               INSTR_SEQUENCER_MUL_EN - when defined, MUL enters MULW and
//               runs a down-counter. When undefined, MUL decodes as a NOP,
//               o_mul_busy is tied low and no counter is built.
// Ports       : i_clk, i_reset_n       - clock, async active-low reset
//               i_instruction          - IR contents (valid from EXEC1)
//               i_mem_ready            - instruction RAM data valid
//               i_resume               - leave HALT (single-cycle pulse)
//               o_state                - current state encoding
//               o_ir_en, o_pc_cnt_en   - IR load, PC increment
//               o_pc_sload             - PC load (jump/call/return)
//               o_reg_write_address    - instruction[REG_ADDR_W+5:6]
//               o_reg_read_address     - instruction[REG_ADDR_W-1:0]
//               o_reg_wren             - register-file write
//               o_ram_wren_data        - data-RAM write (push/call)
//               o_sp                   - stack pointer
//               o_mul_busy             - multiply in progress
//               o_stack_overflow/underflow - sticky traps, cleared by resume
//               o_halted               - in HALT
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_sequencer
  import cpu_pkg::*;
#(
  parameter  int INSTR_W     = 16,
  parameter  int REG_ADDR_W  = 3,
  parameter  int STACK_DEPTH = 8,
  parameter  int MUL_CYCLES  = 4,
  localparam int SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [INSTR_W-1:0]    i_instruction,
  input  logic                  i_mem_ready,
  input  logic                  i_resume,
  output logic [2:0]            o_state,
  output logic                  o_ir_en,
  output logic                  o_pc_cnt_en,
  output logic                  o_pc_sload,
  output logic [REG_ADDR_W-1:0] o_reg_write_address,
  output logic [REG_ADDR_W-1:0] o_reg_read_address,
  output logic                  o_reg_wren,
  output logic                  o_ram_wren_data,
  output logic [SP_W-1:0]       o_sp,
  output logic                  o_mul_busy,
  output logic                  o_stack_overflow,
  output logic                  o_stack_underflow,
  output logic                  o_halted
);

  if (MUL_CYCLES < 2) begin : g_bad_mul_cycles
    $error("instr_sequencer: MUL_CYCLES must be at least 2");
  end

  state_t r_state;
  logic   r_overflow;
  logic   r_underflow;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic [3:0] w_op;
  logic [1:0] w_sub;
  logic       w_is_alu, w_is_push, w_is_pop, w_is_jmd, w_is_call;
  logic       w_is_ldi, w_is_mul, w_is_rtn, w_is_stp;

  assign w_op      = i_instruction[INSTR_W-1 -: 4];
  assign w_sub     = i_instruction[11:10];
  assign w_is_alu  = (w_op == OP_ALU);
  assign w_is_push = (w_op == OP_STACK) && (w_sub == SUB_PUSH);
  assign w_is_pop  = (w_op == OP_STACK) && (w_sub == SUB_POP);
  assign w_is_jmd  = (w_op == OP_JMD);
  assign w_is_call = (w_op == OP_CALL);
  assign w_is_ldi  = (w_op == OP_LDI);
  assign w_is_rtn  = (i_instruction == INSTR_W'(RTN_WORD));
  assign w_is_stp  = (i_instruction == INSTR_W'(STP_WORD));
`ifdef INSTR_SEQUENCER_MUL_EN
  assign w_is_mul  = (w_op[3:1] == OP_MUL);
`else
  assign w_is_mul  = 1'b0;
`endif

  assign o_reg_write_address = i_instruction[REG_ADDR_W+5:6];
  assign o_reg_read_address  = i_instruction[REG_ADDR_W-1:0];

  // --------------------------------------------------------------------------
  // Stack bounds and traps
  // --------------------------------------------------------------------------
  logic w_full, w_empty, w_sp_inc, w_sp_dec;
  logic w_push_like, w_pop_like, w_ovf_trap, w_unf_trap;

  assign w_push_like = w_is_push || w_is_call;
  assign w_pop_like  = w_is_pop  || w_is_rtn;
  assign w_ovf_trap  = (r_state == ST_EXEC1) && w_push_like && w_full;
  assign w_unf_trap  = (r_state == ST_EXEC1) && w_pop_like  && w_empty;

  stack_pointer #(.STACK_DEPTH(STACK_DEPTH)) u_stack_pointer (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_inc     (w_sp_inc),
    .i_dec     (w_sp_dec),
    .o_sp      (o_sp),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // --------------------------------------------------------------------------
  // Multiply down-counter
  // --------------------------------------------------------------------------
`ifdef INSTR_SEQUENCER_MUL_EN
  localparam int CNT_W = $clog2(MUL_CYCLES);
  logic [CNT_W-1:0] r_mul_cnt;

  // EXEC1 is the first multiply cycle. MULW therefore counts
  // MUL_CYCLES-2 .. 0.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_mul_cnt <= '0;
    end else if (r_state == ST_EXEC1 && w_is_mul) begin
      r_mul_cnt <= CNT_W'(MUL_CYCLES - 2);
    end else if (r_state == ST_MULW && r_mul_cnt != '0) begin
      r_mul_cnt <= r_mul_cnt - 1'b1;
    end
  end

  assign o_mul_busy = (r_state == ST_MULW);
`else
  assign o_mul_busy = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Strobes: combinational from state and instruction
  // --------------------------------------------------------------------------
  always_comb begin
    o_ir_en         = 1'b0;
    o_pc_cnt_en     = 1'b0;
    o_pc_sload      = 1'b0;
    o_reg_wren      = 1'b0;
    o_ram_wren_data = 1'b0;
    w_sp_inc        = 1'b0;
    w_sp_dec        = 1'b0;
    case (r_state)
      ST_FETCH: begin
        o_ir_en     = i_mem_ready;
        o_pc_cnt_en = i_mem_ready;
      end
      ST_EXEC1: begin
        // A trapping stack access must have no side effects at all.
        if (!w_ovf_trap && !w_unf_trap) begin
          o_reg_wren      = w_is_alu || w_is_pop;
          o_ram_wren_data = w_push_like;
          o_pc_sload      = w_is_jmd || w_is_call || w_is_rtn;
          w_sp_inc        = w_push_like;
          w_sp_dec        = w_pop_like;
        end
      end
      ST_EXEC2: begin
        o_reg_wren  = i_mem_ready;
        o_pc_cnt_en = i_mem_ready;
      end
`ifdef INSTR_SEQUENCER_MUL_EN
      ST_MULW: begin
        o_reg_wren = (r_mul_cnt == '0);
      end
`endif
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // State machine and sticky trap flags
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= ST_FETCH;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (i_mem_ready) r_state <= ST_EXEC1;
        end
        ST_EXEC1: begin
          if (w_ovf_trap) begin
            r_overflow <= 1'b1;
            r_state    <= ST_HALT;
          end else if (w_unf_trap) begin
            r_underflow <= 1'b1;
            r_state     <= ST_HALT;
          end else if (w_is_ldi) begin
            r_state <= ST_EXEC2;
          end else if (w_is_mul) begin
            r_state <= ST_MULW;
          end else if (w_is_stp) begin
            r_state <= ST_HALT;
          end else begin
            r_state <= ST_FETCH;
          end
        end
        ST_EXEC2: begin
          if (i_mem_ready) r_state <= ST_FETCH;
        end
`ifdef INSTR_SEQUENCER_MUL_EN
        ST_MULW: begin
          if (r_mul_cnt == '0) r_state <= ST_FETCH;
        end
`endif
        ST_HALT: begin
          if (i_resume) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_state     <= ST_FETCH;
          end
        end
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  assign o_state           = r_state;
  assign o_halted          = (r_state == ST_HALT);
  assign o_stack_overflow  = r_overflow;
  assign o_stack_underflow = r_underflow;

endmodule

`default_nettype wire
